// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction beat in, registered ALU operands out.
// master drives instructions and out_ready; slave is the issue stage itself.
interface alu_issue_stage_if #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_instr;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_rs1;
  logic [XLEN-1:0]      in_rs2;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_a;
  logic [XLEN-1:0]      out_b;
  logic [3:0]           out_aluop;
  logic [XLEN-1:0]      out_imm;
  logic [XLEN-1:0]      out_rs2;
  logic [4:0]           out_rd;
  logic                 out_regwrite;
  logic                 out_illegal;
  logic [ILL_CNT_W-1:0] ill_count;

  modport master (
    output in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_aluop, out_imm, out_rs2,
           out_rd, out_regwrite, out_illegal, ill_count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_a, out_b, out_aluop, out_imm, out_rs2,
           out_rd, out_regwrite, out_illegal, ill_count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue into registered ALU operands; 1-cycle latency, one-entry output register.
// Backpressure: in_ready = !out_valid || out_ready, so drain and load overlap without bubbles.
module alu_issue_stage #(
  parameter int XLEN      = 32,
  parameter int ILL_CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_stage_if.slave  bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b0011;
  localparam logic [3:0] ALU_PASSB = 4'b1111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      aluop;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            regwrite;
    logic            illegal;
  } issue_t;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  issue_t dec;
  logic   illegal;
  logic   writes;
  logic   is_shift;

  always_comb begin
    dec      = '0;
    illegal  = 1'b0;
    writes   = 1'b0;
    is_shift = 1'b0;
    dec.rd   = rd;
    dec.rs2  = bus.in_rs2;

    case (opcode)
      OPC_OP: begin
        dec.a     = bus.in_rs1;
        dec.b     = bus.in_rs2;
        dec.aluop = {instr[30], funct3};
        writes    = 1'b1;
        is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
        illegal   = !((funct7 == F7_BASE) ||
                      (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OPIMM: begin
        dec.a     = bus.in_rs1;
        dec.b     = imm_i;
        dec.imm   = imm_i;
        dec.aluop = {(funct3 == 3'b101) && instr[30], funct3};
        writes    = 1'b1;
        is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
        // The upper immediate bits of shifts are funct7 and must be a known pattern.
        if (funct3 == 3'b001)
          illegal = (funct7 != F7_BASE);
        else if (funct3 == 3'b101)
          illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
      end
      OPC_LOAD: begin
        dec.a     = bus.in_rs1;
        dec.b     = imm_i;
        dec.imm   = imm_i;
        dec.aluop = ALU_ADD;
        writes    = 1'b1;
      end
      OPC_STORE: begin
        dec.a     = bus.in_rs1;
        dec.b     = imm_s;
        dec.imm   = imm_s;
        dec.aluop = ALU_ADD;
      end
      OPC_BRANCH: begin
        dec.a   = bus.in_rs1;
        dec.b   = bus.in_rs2;
        dec.imm = imm_b;
        case (funct3)
          3'b000, 3'b001: dec.aluop = ALU_SUB;
          3'b100, 3'b101: dec.aluop = ALU_SLT;
          3'b110, 3'b111: dec.aluop = ALU_SLTU;
          default:        illegal   = 1'b1;
        endcase
      end
      OPC_LUI: begin
        dec.b     = imm_u;
        dec.imm   = imm_u;
        dec.aluop = ALU_PASSB;
        writes    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a     = bus.in_pc;
        dec.b     = imm_u;
        dec.imm   = imm_u;
        dec.aluop = ALU_ADD;
        writes    = 1'b1;
      end
      OPC_JAL: begin
        // The ALU computes the link value pc+4; the target adder uses out_imm.
        dec.a     = bus.in_pc;
        dec.b     = 32'd4;
        dec.imm   = imm_j;
        dec.aluop = ALU_ADD;
        writes    = 1'b1;
      end
      OPC_JALR: begin
        dec.a     = bus.in_pc;
        dec.b     = 32'd4;
        dec.imm   = imm_i;
        dec.aluop = ALU_ADD;
        writes    = 1'b1;
        illegal   = (funct3 != 3'b000);
      end
      default: illegal = 1'b1;
    endcase

    // The ALU shifts by the whole of B, so only the shamt field may reach it.
    if (is_shift)
      dec.b = {{(XLEN-5){1'b0}}, dec.b[4:0]};

    // Illegal ops carry no operands or immediate; rd and rs2 still pass through.
    if (illegal) begin
      dec.a     = '0;
      dec.b     = '0;
      dec.imm   = '0;
      dec.aluop = ALU_PASSB;
      writes    = 1'b0;
    end

    dec.illegal  = illegal;
    dec.regwrite = writes && (rd != 5'd0);
  end

  issue_t               held;
  logic                 vld;
  logic [ILL_CNT_W-1:0] ill_q;
  logic                 load;

  assign bus.in_ready = !vld || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      held  <= '0;
      ill_q <= '0;
    end else begin
      if (load) begin
        held <= dec;
        vld  <= 1'b1;
        if (dec.illegal && (ill_q != {ILL_CNT_W{1'b1}}))
          ill_q <= ill_q + 1'b1;
      end else if (bus.out_ready) begin
        vld <= 1'b0;
      end
    end
  end

  assign bus.out_valid    = vld;
  assign bus.out_a        = held.a;
  assign bus.out_b        = held.b;
  assign bus.out_aluop    = held.aluop;
  assign bus.out_imm      = held.imm;
  assign bus.out_rs2      = held.rs2;
  assign bus.out_rd       = held.rd;
  assign bus.out_regwrite = held.regwrite;
  assign bus.out_illegal  = held.illegal;
  assign bus.ill_count    = ill_q;

endmodule
